// File: rtl/hht_pkg.sv
// Shared types and defaults for the HHT column-update datapath.
package hht_pkg;

  localparam int unsigned HHT_DW      = 32;
  localparam int unsigned HHT_MAX_LEN = 32;

  typedef logic signed [HHT_DW-1:0] hht_data_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC   = 3'd1,
    ST_SCALE = 3'd2,
    ST_WRITE = 3'd3,
    ST_FIN   = 3'd4
  } hht_upd_state_t;

endpackage

// File: rtl/hht_mac.sv
// Registered signed multiply-accumulate: acc <= acc + sext64(a)*sext64(b), wraps at 64 bits.
module hht_mac
  import hht_pkg::*;
#(
  parameter int unsigned DW = HHT_DW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 en,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [63:0]   acc
);

  logic signed [63:0] acc_q, acc_d, prod;

  // Next accumulator value; clear wins over accumulate.
  always_comb begin
    prod  = 64'(a) * 64'(b);
    acc_d = acc_q;
    if (clear) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q + prod;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/hht_col_update.sv
// HHT column update: buffers a streamed column, accumulates s = sum(v*x),
// then writes x' = x - ((s_lo32 * v) >>> SCALE_SH) back at base+i.
module hht_col_update
  import hht_pkg::*;
#(
  parameter  int unsigned MAX_LEN  = HHT_MAX_LEN,
  parameter  int unsigned DW       = HHT_DW,
  parameter  int unsigned SCALE_SH = 0,
  localparam int unsigned LW       = $clog2(MAX_LEN) + 1
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 start,
  input  logic [31:0]          wr_col_base,
  input  logic [LW-1:0]        len,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_v,
  input  logic signed [DW-1:0] in_x,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [31:0]          wr_addr,
  output logic signed [DW-1:0] wr_data,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int unsigned AW = $clog2(MAX_LEN);

  hht_upd_state_t state_q, state_d;
  logic [31:0]    base_q, base_d;
  logic [LW-1:0]  len_q, len_d;
  logic [LW-1:0]  idx_q, idx_d;
  logic           wr_en_q, wr_en_d;
  logic [31:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]  wr_data_q, wr_data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic                 xfer, last, len_ok, mac_clear;
  logic signed [63:0]   s;
  logic signed [31:0]   s_lo;
  logic signed [DW-1:0] v_rd, x_rd;
  logic signed [DW-1:0] wr_res;
  logic signed [63:0]   wr_prod, wr_shift;
  logic                 unused_bits;

  logic signed [DW-1:0] v_buf_q [MAX_LEN];
  logic signed [DW-1:0] x_buf_q [MAX_LEN];

  assign in_ready = (state_q == ST_ACC);
  assign xfer     = in_valid && in_ready;
  assign last     = (idx_q == len_q - LW'(1));
  assign len_ok   = (len != '0) && (32'(len) <= MAX_LEN);

  hht_mac #(.DW(DW)) u_mac (
    .clk   (Clk),
    .rst_n (Rst),
    .clear (mac_clear),
    .en    (xfer),
    .a     (in_v),
    .b     (in_x),
    .acc   (s)
  );

  // Write-phase datapath: reflected element for the current buffer slot.
  always_comb begin
    v_rd     = v_buf_q[idx_q[AW-1:0]];
    x_rd     = x_buf_q[idx_q[AW-1:0]];
    s_lo     = s[31:0];
    wr_prod  = 64'(s_lo) * 64'(v_rd);
    wr_shift = wr_prod >>> SCALE_SH;
    wr_res   = x_rd - wr_shift[DW-1:0];
  end

  assign unused_bits = ^{s[63:32], wr_shift[63:DW]};

  // Column sequencing and registered write-port outputs.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    idx_d     = idx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = err_q;
    mac_clear = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // busy falls the cycle after the done pulse
        if (done_q) busy_d = 1'b0;
        if (start) begin
          if (len_ok) begin
            base_d    = wr_col_base;
            len_d     = len;
            idx_d     = '0;
            mac_clear = 1'b1;
            err_d     = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_ACC;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ACC: begin
        if (xfer) begin
          idx_d = idx_q + LW'(1);
          if (last) state_d = ST_SCALE;
        end
      end
      ST_SCALE: begin
        idx_d   = '0;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        wr_en_d   = 1'b1;
        wr_addr_d = base_q + 32'(idx_q);
        wr_data_d = wr_res;
        if (last) state_d = ST_FIN;
        else      idx_d   = idx_q + LW'(1);
      end
      ST_FIN: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // Column buffer; contents are only meaningful after the ACC phase fills them.
  always_ff @(posedge Clk) begin
    if (xfer) begin
      v_buf_q[idx_q[AW-1:0]] <= in_v;
      x_buf_q[idx_q[AW-1:0]] <= in_x;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

// File: tb/tb_hht_col_update.sv
// Bench for hht_col_update: table vectors, directed corner sequences and
// random columns checked against an arithmetic model of the column update.
module tb_hht_col_update;

  localparam int unsigned MAXL = 32;
  localparam int unsigned SH   = 0;

  logic        Clk = 1'b0;
  logic        Rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] wr_col_base = '0;
  logic [5:0]  len = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_v = '0, in_x = '0;
  logic        in_ready, wr_en, busy, done, err;
  logic [31:0] wr_addr, wr_data;

  hht_col_update #(.MAX_LEN(MAXL), .DW(32), .SCALE_SH(SH)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .wr_col_base(wr_col_base), .len(len),
    .in_valid(in_valid), .in_v(in_v), .in_x(in_x), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0, bad = 0;
  int          cur_v [MAXL];
  int          cur_x [MAXL];
  int          exp_d [MAXL];
  logic [31:0] exp_a [MAXL];

  typedef struct packed {
    logic [31:0]      base;
    int               n;
    int               gap;
    logic [0:3][31:0] v;
    logic [0:3][31:0] x;
    logic [0:3][31:0] ea;
    logic [0:3][31:0] ed;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input longint got, input longint want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference: s accumulated in 64-bit, low word times v, shifted, subtracted.
  function automatic void model(input logic [31:0] base, input int n);
    longint s;
    int     slo;
    s = 0;
    for (int i = 0; i < n; i++) s += longint'(cur_v[i]) * longint'(cur_x[i]);
    slo = int'(s[31:0]);
    for (int i = 0; i < n; i++) begin
      exp_a[i] = base + 32'(i);
      exp_d[i] = cur_x[i] - int'((longint'(slo) * longint'(cur_v[i])) >>> SH);
    end
  endfunction

  // gap: 0 = back-to-back, 1 = valid every other cycle, 2 = random valid.
  // abort > 0: pull reset right after that many writes have been observed.
  task automatic run_col(input string tag, input logic [31:0] base, input int n,
                         input int gap, input int abort);
    int  i, c_last, first_wr, last_wr, done_c, nwr, guard;
    bit  xf, got_done;
    i = 0; c_last = 0; first_wr = -1; last_wr = 0; done_c = 0; nwr = 0; guard = 0;
    got_done = 0;
    @(negedge Clk);
    start = 1'b1; wr_col_base = base; len = 6'(n);
    @(negedge Clk);
    start = 1'b0;
    check({tag, " busy_after_start"}, longint'(busy), 1);
    check({tag, " err_after_start"}, longint'(err), 0);
    while (i < n && guard < 400) begin
      case (gap)
        0:       in_valid = 1'b1;
        1:       in_valid = (guard % 2) == 0;
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_v = cur_v[i]; in_x = cur_x[i];
      xf = in_valid && in_ready;
      @(negedge Clk);
      guard++;
      if (xf) begin
        i++;
        if (i == n) c_last = cyc;
      end
    end
    check({tag, " all_transferred"}, longint'(i), longint'(n));
    check({tag, " in_ready_low_after_last"}, longint'(in_ready), 0);
    guard = 0;
    while (!got_done && guard < 200) begin
      if (wr_en) begin
        if (nwr < n) begin
          check($sformatf("%s addr[%0d]", tag, nwr), longint'(wr_addr), longint'(exp_a[nwr]));
          check($sformatf("%s data[%0d]", tag, nwr), longint'(int'(wr_data)), longint'(exp_d[nwr]));
        end
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        nwr++;
        if (abort > 0 && nwr == abort) begin
          Rst = 1'b0;
          #1;
          check({tag, " wr_en_at_reset"}, longint'(wr_en), 0);
          check({tag, " busy_at_reset"}, longint'(busy), 0);
          check({tag, " done_at_reset"}, longint'(done), 0);
          in_valid = 1'b0;
          return;
        end
      end
      if (done) begin
        done_c = cyc;
        got_done = 1;
      end else begin
        // garbage on the input side must be ignored outside ACC
        in_valid = 1'($urandom_range(0, 1));
        in_v = $urandom; in_x = $urandom;
        @(negedge Clk);
        guard++;
      end
    end
    check({tag, " done_seen"}, longint'(got_done), 1);
    check({tag, " write_count"}, longint'(nwr), longint'(n));
    check({tag, " first_wr_latency"}, longint'(first_wr - c_last), 2);
    check({tag, " done_after_last_wr"}, longint'(done_c - last_wr), 1);
    check({tag, " done_latency"}, longint'(done_c - c_last), longint'(n + 2));
    @(negedge Clk);
    in_valid = 1'b0;
    check({tag, " done_one_cycle"}, longint'(done), 0);
    check({tag, " busy_low_after_done"}, longint'(busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, k, gap, cnt;
    logic [31:0] base;

    tbl[0] = '{base: 32'd340, n: 3, gap: 0,
               v: '{32'd1, 32'd2, 32'd3, 32'd0}, x: '{32'd4, 32'd5, 32'd6, 32'd0},
               ea: '{32'd340, 32'd341, 32'd342, 32'd0},
               ed: '{-32'sd28, -32'sd59, -32'sd90, 32'd0}};
    tbl[1] = tbl[0];
    tbl[1].gap = 1;
    tbl[2] = '{base: 32'hFFFF_FFFF, n: 2, gap: 0,
               v: '{32'd2, -32'sd1, 32'd0, 32'd0}, x: '{32'd3, 32'd7, 32'd0, 32'd0},
               ea: '{32'hFFFF_FFFF, 32'h0000_0000, 32'd0, 32'd0},
               ed: '{32'd5, 32'd6, 32'd0, 32'd0}};
    tbl[3] = '{base: 32'd0, n: 1, gap: 2,
               v: '{-32'sd5, 32'd0, 32'd0, 32'd0}, x: '{32'd10, 32'd0, 32'd0, 32'd0},
               ea: '{32'd0, 32'd0, 32'd0, 32'd0},
               ed: '{-32'sd240, 32'd0, 32'd0, 32'd0}};
    tbl[4] = '{base: 32'd100, n: 4, gap: 1,
               v: '{32'd1, -32'sd1, 32'd2, 32'd0}, x: '{32'd3, 32'd3, -32'sd4, 32'd9},
               ea: '{32'd100, 32'd101, 32'd102, 32'd103},
               ed: '{32'd11, -32'sd5, 32'd12, 32'd9}};

    // Reset state
    repeat (3) @(negedge Clk);
    check("reset in_ready", longint'(in_ready), 0);
    check("reset wr_en", longint'(wr_en), 0);
    check("reset busy", longint'(busy), 0);
    check("reset done", longint'(done), 0);
    check("reset err", longint'(err), 0);
    check("reset wr_addr", longint'(wr_addr), 0);
    check("reset wr_data", longint'(wr_data), 0);
    Rst = 1'b1;

    // Table vectors
    for (int t = 0; t < 5; t++) begin
      for (int i = 0; i < tbl[t].n; i++) begin
        cur_v[i] = int'(tbl[t].v[i]);
        cur_x[i] = int'(tbl[t].x[i]);
        exp_a[i] = tbl[t].ea[i];
        exp_d[i] = int'(tbl[t].ed[i]);
      end
      run_col($sformatf("tbl%0d", t), tbl[t].base, tbl[t].n, tbl[t].gap, 0);
    end

    // Full-length column: v=1, x=i, s=496
    for (int i = 0; i < 32; i++) begin
      cur_v[i] = 1; cur_x[i] = i;
      exp_a[i] = 32'd2000 + 32'(i);
      exp_d[i] = i - 496;
    end
    run_col("full32", 32'd2000, 32, 0, 0);

    // Invalid lengths: err set, nothing started
    for (int t = 0; t < 2; t++) begin
      @(negedge Clk);
      start = 1'b1; len = (t == 0) ? 6'd0 : 6'd33;
      @(negedge Clk);
      start = 1'b0;
      check($sformatf("badlen%0d err", t), longint'(err), 1);
      cnt = 0;
      for (int c = 0; c < 5; c++) begin
        if (busy || wr_en || done || in_ready) cnt++;
        @(negedge Clk);
      end
      check($sformatf("badlen%0d no_activity", t), longint'(cnt), 0);
    end
    // following valid start clears err (checked inside run_col)
    cur_v[0] = 7; cur_x[0] = -3;
    model(32'd55, 1);
    run_col("err_clear", 32'd55, 1, 0, 0);

    // Reset during WRITE after 2 of 4 writes
    cur_v[0] = 3; cur_v[1] = -2; cur_v[2] = 5; cur_v[3] = 1;
    cur_x[0] = 7; cur_x[1] = 8; cur_x[2] = -1; cur_x[3] = 4;
    model(32'd500, 4);
    run_col("rst_mid", 32'd500, 4, 0, 2);
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (wr_en || done || busy) cnt++;
    end
    check("rst_mid quiet_in_reset", longint'(cnt), 0);
    Rst = 1'b1;
    model(32'd600, 4);
    run_col("after_rst", 32'd600, 4, 0, 0);

    // Random columns against the model
    for (k = 0; k < 12; k++) begin
      n = $urandom_range(1, 32);
      base = $urandom;
      gap = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        if (k % 2 == 0) begin
          cur_v[i] = int'($urandom_range(0, 200)) - 100;
          cur_x[i] = int'($urandom_range(0, 200)) - 100;
        end else begin
          cur_v[i] = $urandom;
          cur_x[i] = $urandom;
        end
      end
      model(base, n);
      run_col($sformatf("rnd%0d", k), base, n, gap, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
